// File: rtl/drops_sequencer_if.sv
// Handshake bundle between the drops game-loop sequencer and the board/stage blocks.
// The master side is the sequencer; the slave side is whatever drives the stages and board I/O.
interface drops_sequencer_if;
    logic       start_i;
    logic       pause_i;
    logic       d_inp_i;
    logic       d_act_i;
    logic       over_i;
    logic       d_disp_i;
    logic       e_inp_o;
    logic       e_act_o;
    logic       e_disp_o;
    logic [2:0] level_o;
    logic [7:0] frame_o;
    logic       timeout_o;
    logic [2:0] state_o;

    modport master (
        input  start_i, pause_i, d_inp_i, d_act_i, over_i, d_disp_i,
        output e_inp_o, e_act_o, e_disp_o, level_o, frame_o, timeout_o, state_o
    );

    modport slave (
        output start_i, pause_i, d_inp_i, d_act_i, over_i, d_disp_i,
        input  e_inp_o, e_act_o, e_disp_o, level_o, frame_o, timeout_o, state_o
    );
endinterface

// File: rtl/drops_sequencer.sv
// Round-robin game-loop controller: input -> action -> display, with per-stage watchdog,
// frame-end pause, game-over hold and frame/level counters used to scale drop speed.
module drops_sequencer #(
    parameter int TIMEOUT        = 255,
    parameter int TO_W           = 8,
    parameter int FRAMES_PER_LVL = 16,
    parameter int LVL_MAX        = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    drops_sequencer_if.master bus
);
    localparam int SUB_W = $clog2(FRAMES_PER_LVL + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INP   = 3'd1,
        S_ACT   = 3'd2,
        S_DISP  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       frame_q, frame_d;
    logic             over_q, over_d;
    logic             timeout_q, timeout_d;
    logic             e_inp_q, e_act_q, e_disp_q;

    logic in_stage, done_acc, wd_exp, adv;

    function automatic logic [2:0] sat_level_inc(input logic [2:0] lvl);
        return (lvl >= 3'(LVL_MAX)) ? 3'(LVL_MAX) : lvl + 3'd1;
    endfunction

    // A done only counts while its own enable is already high; wd_q holds cycles-in-stage minus one.
    always_comb begin
        in_stage = e_inp_q | e_act_q | e_disp_q;
        done_acc = (e_inp_q & bus.d_inp_i) | (e_act_q & bus.d_act_i) | (e_disp_q & bus.d_disp_i);
        wd_exp   = in_stage & ~done_acc & (wd_q == TO_W'(TIMEOUT - 1));
        adv      = done_acc | wd_exp;
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = (in_stage && !adv) ? wd_q + TO_W'(1) : '0;
        sub_d     = sub_q;
        level_d   = level_q;
        frame_d   = frame_q;
        over_d    = over_q;
        timeout_d = timeout_q | wd_exp;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_INP;
            S_INP:   if (adv) state_d = S_ACT;
            S_ACT: begin
                if (adv) state_d = S_DISP;
                if (done_acc && bus.over_i) over_d = 1'b1;
            end
            S_DISP: begin
                if (adv) begin
                    frame_d = frame_q + 8'd1;
                    if (sub_q == SUB_W'(FRAMES_PER_LVL - 1)) begin
                        sub_d   = '0;
                        level_d = sat_level_inc(level_q);
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                    if (over_q)           state_d = S_OVER;
                    else if (bus.pause_i) state_d = S_PAUSE;
                    else                  state_d = S_INP;
                end
            end
            S_PAUSE: if (!bus.pause_i) state_d = S_INP;
            S_OVER: begin
                if (bus.start_i) begin
                    state_d = S_INP;
                    frame_d = '0;
                    level_d = '0;
                    sub_d   = '0;
                    over_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are registered from the next state so one falls as the next rises.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            sub_q     <= '0;
            level_q   <= '0;
            frame_q   <= '0;
            over_q    <= 1'b0;
            timeout_q <= 1'b0;
            e_inp_q   <= 1'b0;
            e_act_q   <= 1'b0;
            e_disp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            sub_q     <= sub_d;
            level_q   <= level_d;
            frame_q   <= frame_d;
            over_q    <= over_d;
            timeout_q <= timeout_d;
            e_inp_q   <= (state_d == S_INP);
            e_act_q   <= (state_d == S_ACT);
            e_disp_q  <= (state_d == S_DISP);
        end
    end

    assign bus.e_inp_o   = e_inp_q;
    assign bus.e_act_o   = e_act_q;
    assign bus.e_disp_o  = e_disp_q;
    assign bus.level_o   = level_q;
    assign bus.frame_o   = frame_q;
    assign bus.timeout_o = timeout_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_drops_sequencer.sv
// Bench for drops_sequencer: plays the three stage blocks with random stage lengths and
// stray handshakes, and checks stage lengths and frame/level/timeout/state against a frame-level model.
module tb_drops_sequencer;
    localparam int TIMEOUT = 255;
    localparam int FPL     = 16;
    localparam int LMAX    = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drops_sequencer_if bus ();

    drops_sequencer #(
        .TIMEOUT(TIMEOUT), .TO_W(8), .FRAMES_PER_LVL(FPL), .LVL_MAX(LMAX)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Frame-level reference model
    int m_frames = 0;
    bit m_over   = 1'b0;
    bit m_to     = 1'b0;
    bit force_over = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic en_of(input int st);
        case (st)
            1: return bus.e_inp_o;
            2: return bus.e_act_o;
            3: return bus.e_disp_o;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_len(input int dur);
        return (dur == 0) ? TIMEOUT : dur;
    endfunction

    function automatic int exp_level();
        return (m_frames / FPL > LMAX) ? LMAX : m_frames / FPL;
    endfunction

    function automatic int n_en();
        return 32'(bus.e_inp_o) + 32'(bus.e_act_o) + 32'(bus.e_disp_o);
    endfunction

    // Called at a falling edge where stage st should be enabled; dur==0 means never send done.
    task automatic run_stage(input int st, input int dur, input bit ov, output int cyc);
        cyc = 0;
        check($sformatf("enter_st%0d", st), 32'(en_of(st)), 1);
        while (en_of(st) === 1'b1 && cyc < 400) begin
            cyc++;
            check("onehot", n_en(), 1);
            bus.d_inp_i  = (st == 1) ? (cyc == dur) : rbit();
            bus.d_act_i  = (st == 2) ? (cyc == dur) : rbit();
            bus.d_disp_i = (st == 3) ? (cyc == dur) : rbit();
            bus.over_i   = (st == 2 && cyc == dur) ? ov : (force_over | rbit());
            bus.start_i  = rbit();
            @(posedge clk);
            #1;
            bus.d_inp_i  = 1'b0;
            bus.d_act_i  = 1'b0;
            bus.d_disp_i = 1'b0;
            bus.over_i   = 1'b0;
            bus.start_i  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int di, input int da, input int dd, input bit ov, input int pz);
        int c;
        int exp_state;
        run_stage(1, di, 1'b0, c);
        check("inp_len", c, exp_len(di));
        if (pz > 0) bus.pause_i = 1'b1;
        run_stage(2, da, ov, c);
        check("act_len", c, exp_len(da));
        run_stage(3, dd, 1'b0, c);
        check("disp_len", c, exp_len(dd));
        m_frames++;
        if (ov && da != 0) m_over = 1'b1;
        if (di == 0 || da == 0 || dd == 0) m_to = 1'b1;
        check("frame", bus.frame_o, m_frames % 256);
        check("level", bus.level_o, exp_level());
        check("timeout", bus.timeout_o, m_to);
        exp_state = m_over ? 5 : ((pz > 0) ? 4 : 1);
        check("state_end", bus.state_o, exp_state);
        if (pz > 0 && !m_over) begin
            for (int i = 1; i <= pz; i++) begin
                check("pause_state", bus.state_o, 4);
                check("pause_noen", n_en(), 0);
                check("pause_frame", bus.frame_o, m_frames % 256);
                if (i == pz) bus.pause_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic rand_frame();
        int pz;
        pz = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
        run_frame($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5), 1'b0, pz);
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.pause_i  = 1'b0;
        bus.d_inp_i  = 1'b0;
        bus.d_act_i  = 1'b0;
        bus.over_i   = 1'b0;
        bus.d_disp_i = 1'b0;
        @(negedge clk);
        check("rst_state", bus.state_o, 0);
        check("rst_en", n_en(), 0);
        check("rst_level", bus.level_o, 0);
        check("rst_frame", bus.frame_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        rst = 1'b0;

        // A done while idle is ignored
        bus.d_inp_i = 1'b1;
        @(posedge clk);
        #1 bus.d_inp_i = 1'b0;
        @(negedge clk);
        check("idle_ignore_state", bus.state_o, 0);
        check("idle_ignore_en", n_en(), 0);

        pulse_start();
        run_frame(3, 3, 3, 1'b0, 0);
        check("first_frame", bus.frame_o, 1);

        while (m_frames < 16) rand_frame();
        check("lvl_at16", bus.level_o, 1);
        check("frame_at16", bus.frame_o, 16);
        while (m_frames < 112) rand_frame();
        check("lvl_at112", bus.level_o, 7);
        while (m_frames < 128) rand_frame();
        check("lvl_sat128", bus.level_o, 7);
        check("frame_at128", bus.frame_o, 128);

        // Done exactly at the timeout edge wins; then a forced ACT exit with over_i held high
        run_frame(2, TIMEOUT, 2, 1'b0, 0);
        check("done_wins_to", bus.timeout_o, 0);
        force_over = 1'b1;
        run_frame(2, 0, 2, 1'b0, 0);
        force_over = 1'b0;
        check("forced_to", bus.timeout_o, 1);

        run_frame(1, 3, 2, 1'b0, 10);
        check("after_pause_state", bus.state_o, 1);

        run_frame(2, 2, 2, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            bus.d_inp_i = 1'b1;
            bus.d_disp_i = 1'b1;
            @(posedge clk);
            #1;
            bus.d_inp_i = 1'b0;
            bus.d_disp_i = 1'b0;
            @(negedge clk);
            check("over_hold", bus.state_o, 5);
            check("over_noen", n_en(), 0);
        end
        pulse_start();
        m_frames = 0;
        m_over   = 1'b0;
        check("restart_frame", bus.frame_o, 0);
        check("restart_level", bus.level_o, 0);
        check("restart_state", bus.state_o, 1);
        check("restart_keep_to", bus.timeout_o, 1);
        run_frame(1, 1, 1, 1'b0, 0);

        // Asynchronous reset in the middle of DISP
        run_stage(1, 2, 1'b0, c);
        run_stage(2, 2, 1'b0, c);
        check("pre_rst_disp", bus.e_disp_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_en", n_en(), 0);
        check("async_rst_state", bus.state_o, 0);
        check("async_rst_frame", bus.frame_o, 0);
        check("async_rst_level", bus.level_o, 0);
        check("async_rst_to", bus.timeout_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.d_disp_i = 1'b1;
        @(posedge clk);
        #1 bus.d_disp_i = 1'b0;
        @(negedge clk);
        check("post_rst_state", bus.state_o, 0);
        check("post_rst_en", n_en(), 0);
        check("post_rst_frame", bus.frame_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/drops_sequencer.md
Name: drops_sequencer

Overview:
- Game-loop controller for the drops display.
- Runs the input, action and display stages in a fixed round-robin using enable/done handshakes.
- Adds a per-stage watchdog, a pause hook, a game-over terminal state, and frame/level counters that the action stage uses to scale drop speed.
- Sits at the top of the design, between the board I/O and the three stage blocks.

Parameters:
- TIMEOUT, 255: cycles a stage may hold its enable before the sequencer forces it to advance.
- TO_W, 8: width of the watchdog counter; must satisfy TIMEOUT < 2**TO_W.
- FRAMES_PER_LVL, 16: completed frames per level increment.
- LVL_MAX, 7: level saturation value.

Ports:
- clk_i  in  1  system clock; all logic runs on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; acted on only in IDLE or OVER.
- pause_i  in  1  pause request (level); sampled only at frame end.
- d_inp_i  in  1  done from input stage.
- d_act_i  in  1  done from action stage.
- over_i  in  1  game-over flag from action stage; qualified by d_act_i.
- d_disp_i  in  1  done from display stage.
- e_inp_o  out  1  enable to input stage.
- e_act_o  out  1  enable to action stage.
- e_disp_o  out  1  enable to display stage.
- level_o  out  3  current level, 0..LVL_MAX.
- frame_o  out  8  completed-frame counter.
- timeout_o  out  1  sticky watchdog flag.
- state_o  out  3  FSM state, for debug.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, all enables 0, level_o=0, frame_o=0, timeout_o=0.
  - Watchdog counter, level sub-counter and over latch cleared.
  - Asserting reset mid-stage drops the stage's enable immediately, with no wait for a clock edge.
- State encoding: IDLE=0, INP=1, ACT=2, DISP=3, PAUSE=4, OVER=5.
- Enable outputs are registered: e_inp_o=(state==INP), e_act_o=(state==ACT), e_disp_o=(state==DISP). Exactly one or none is high.
- Handshake:
  - A done is accepted only at an edge where that stage's own enable is already high. A done at any other time is ignored.
  - On acceptance, the FSM advances at that edge. The old enable falls and the next enable rises on the same edge, so there is no gap cycle.
  - A stage that asserts done in its first enabled cycle therefore takes 1 cycle.
- Transitions:
  - IDLE -> INP on start_i.
  - INP -> ACT on accepted d_inp_i.
  - ACT -> DISP on accepted d_act_i. If over_i=1 at that edge, the over latch is set.
  - DISP -> OVER on completion if the over latch is set.
  - Otherwise DISP -> PAUSE on completion if pause_i=1.
  - Otherwise DISP -> INP on completion.
  - PAUSE -> INP at the first edge with pause_i=0.
  - OVER -> INP on start_i. At that same edge frame_o, level_o, the level sub-counter and the over latch are cleared; timeout_o is kept.
  - start_i in any other state is ignored.
- Watchdog:
  - The counter clears on entry to INP, ACT or DISP and increments each cycle the FSM stays in that stage.
  - When the counter equals TIMEOUT with no done accepted at that edge: timeout_o is set (sticky until reset) and the FSM advances exactly as if done had arrived.
  - A forced ACT exit does not set the over latch.
  - If done and timeout coincide, done wins and timeout_o is not set.
  - The watchdog is idle in IDLE, PAUSE and OVER.
- Frame/level (on DISP completion, whether by done or by forced exit):
  - frame_o increments, wrapping 255 -> 0.
  - The level sub-counter increments. When it reaches FRAMES_PER_LVL it clears, and level_o increments, saturating at LVL_MAX.
  - The final DISP before OVER counts as a frame.
- pause_i has no effect mid-stage; a pause takes effect only at frame end.

Test Plan:
- Reset then start_i pulse; each stage blocks its done for 3 enabled cycles, then asserts it -> enables walk INP->ACT->DISP, each high exactly 3 cycles with no overlap or gap; frame_o=1 after the first DISP; timeout_o=0.
- Run 16 frames -> level_o=1 and frame_o=16; run 112 frames total -> level_o=7; run 16 more -> level_o stays 7.
- Hold d_act_i low with TIMEOUT=255 -> e_act_o stays high 255 cycles, then falls as e_disp_o rises; timeout_o=1; then assert d_act_i exactly at the timeout edge in a later frame -> done wins, and the advance is normal.
- pause_i=1 during ACT, then dropped 10 cycles into PAUSE -> DISP still completes; state_o=4 for those 10 cycles; no enables high; INP re-entered on the release edge; frame_o not incremented in PAUSE.
- over_i=1 with d_act_i -> DISP runs once; state_o=5; frame_o incremented; start_i -> frame_o=0, level_o=0, state INP.
- Assert rst_i asynchronously while e_disp_o=1 -> all enables drop before the next clock edge; state_o=0; counters=0; a later d_disp_i pulse is ignored.
